niosii_processor_nios2_gen2_0_cpu_debug_ocimem: RTL

On-chip debug memory for the Nios II debug slave: a 256 x 32 RAM shared between the JTAG debug path and the CPU's Avalon debug slave port. It consumes `jdo` and the `take_action_ocimem_*` strobes produced in the system-clock domain of the debug slave wrapper. It returns `MonDReg` to that wrapper for shift-out.

---
 rtl/nios2_ocimem_pkg.sv | 19 +
 rtl/niosii_processor_nios2_gen2_0_cpu_debug_ocimem_if.sv | 16 +
 rtl/niosII_processor_nios2_gen2_0_cpu_ociram_sp_ram.sv | 20 ++
 rtl/niosii_processor_nios2_gen2_0_cpu_debug_ocimem.sv | 87 ++++++++
 4 files changed

// File: rtl/nios2_ocimem_pkg.sv
// nios2_ocimem_pkg: shared types and jdo field positions for the debug on-chip memory
package nios2_ocimem_pkg;
  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_DEPTH = 2 ** RAM_ADDR_W;
  localparam int JDO_RD_BIT = 35;
  localparam int JDO_ADDR_HI = 33;
  localparam int JDO_ADDR_LO = 26;
  localparam int JDO_DATA_HI = 34;
  localparam int JDO_DATA_LO = 3;
  typedef enum logic [2:0] {IDLE, J_RD, J_CAP, J_WR, AV_RD, AV_ACK} state_e;
  typedef enum logic [1:0] {CMD_NONE, CMD_SET, CMD_INC, CMD_WR} cmd_e;
  typedef struct packed {
    cmd_e cmd;
    logic rd;
    logic [JDO_ADDR_HI-JDO_ADDR_LO:0] addr;
    logic [JDO_DATA_HI-JDO_DATA_LO:0] data;
  } jcmd_t;
endpackage

// File: rtl/niosii_processor_nios2_gen2_0_cpu_debug_ocimem_if.sv
// niosii_processor_nios2_gen2_0_cpu_debug_ocimem_if: Avalon debug slave bus
interface niosii_processor_nios2_gen2_0_cpu_debug_ocimem_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] address;
  logic chipselect;
  logic read;
  logic write;
  logic [3:0] byteenable;
  logic [31:0] writedata;
  logic debugaccess;
  logic [31:0] readdata;
  logic waitrequest;
  modport master(output address, chipselect, read, write, byteenable, writedata, debugaccess,
                 input readdata, waitrequest);
  modport slave(input address, chipselect, read, write, byteenable, writedata, debugaccess,
                output readdata, waitrequest);
endinterface

// File: rtl/niosII_processor_nios2_gen2_0_cpu_ociram_sp_ram.sv
// niosII_processor_nios2_gen2_0_cpu_ociram_sp_ram: byte-enable single-port RAM, 1-cycle read latency
module niosII_processor_nios2_gen2_0_cpu_ociram_sp_ram
  import nios2_ocimem_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH,
  parameter int DW = RAM_DATA_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic [AW-1:0] addr_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < DW / 8; i++) if (be_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
    rdata_o <= mem[addr_i];
  end
endmodule

// File: rtl/niosii_processor_nios2_gen2_0_cpu_debug_ocimem.sv
// niosii_processor_nios2_gen2_0_cpu_debug_ocimem: debug RAM shared by JTAG commands and Avalon slave
module niosii_processor_nios2_gen2_0_cpu_debug_ocimem
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [37:0] jdo,
  input  logic take_action_ocimem_a,
  input  logic take_no_action_ocimem_a,
  input  logic take_action_ocimem_b,
  niosii_processor_nios2_gen2_0_cpu_debug_ocimem_if.slave av,
  output logic [DATA_W-1:0] MonDReg,
  output logic [ADDR_W-1:0] MonAReg
);
  state_e state_q;
  jcmd_t pend_q, strobe, cmd;
  logic [ADDR_W-1:0] mona_q, ram_addr;
  logic [DATA_W-1:0] mond_q, rdata_q, ram_wdata, ram_q;
  logic [DATA_W/8-1:0] ram_be;
  logic idle, jtag_go, av_req, av_rd, av_wr, unused_jdo;
  always_comb begin
    strobe.cmd = take_action_ocimem_b ? CMD_WR : take_no_action_ocimem_a ? CMD_INC :
                 take_action_ocimem_a ? CMD_SET : CMD_NONE;
    strobe.rd = jdo[JDO_RD_BIT];
    strobe.addr = jdo[JDO_ADDR_HI:JDO_ADDR_LO];
    strobe.data = jdo[JDO_DATA_HI:JDO_DATA_LO];
  end
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
  // a latched command is older than any strobe, so it is served first
  assign cmd = (pend_q.cmd != CMD_NONE) ? pend_q : strobe;
  assign idle = state_q == IDLE;
  assign jtag_go = idle && cmd.cmd != CMD_NONE;
  assign av_req = av.chipselect && (av.read || av.write);
  assign av_rd = idle && !jtag_go && av_req && av.read;
  assign av_wr = idle && !jtag_go && av_req && !av.read;
  assign av.waitrequest = av_req && state_q != AV_ACK && !av_wr;
  assign av.readdata = rdata_q;
  assign ram_addr = (state_q == J_RD || state_q == J_WR) ? mona_q : av.address;
  assign ram_be = (state_q == J_WR) ? '1 : (av_wr && av.debugaccess) ? av.byteenable : '0;
  assign ram_wdata = (state_q == J_WR) ? mond_q : av.writedata;
  assign MonAReg = mona_q;
  assign MonDReg = mond_q;
  niosII_processor_nios2_gen2_0_cpu_ociram_sp_ram #(.DEPTH(2 ** ADDR_W), .DW(DATA_W)) u_ram (
    .clk(clk), .addr_i(ram_addr), .be_i(ram_be), .wdata_i(ram_wdata), .rdata_o(ram_q)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q <= '0;
      mona_q <= '0;
      mond_q <= '0;
      rdata_q <= '0;
    end else begin
      pend_q <= (strobe.cmd != CMD_NONE && (!idle || pend_q.cmd != CMD_NONE)) ? strobe :
                jtag_go ? '0 : pend_q;
      case (state_q)
        IDLE:
          if (jtag_go) begin
            if (cmd.cmd == CMD_WR) begin
              mond_q <= DATA_W'(cmd.data);
              state_q <= J_WR;
            end else begin
              mona_q <= (cmd.cmd == CMD_SET) ? ADDR_W'(cmd.addr) : mona_q + 1'b1;
              state_q <= (cmd.cmd == CMD_INC || cmd.rd) ? J_RD : IDLE;
            end
          end else if (av_rd) state_q <= AV_RD;
        J_RD: state_q <= J_CAP;
        J_CAP: begin
          mond_q <= ram_q;
          state_q <= IDLE;
        end
        J_WR: begin
          mona_q <= mona_q + 1'b1;
          state_q <= IDLE;
        end
        AV_RD: begin
          rdata_q <= ram_q;
          state_q <= AV_ACK;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
